router_xbar_ravenoc: RTL and testbench

//  Parametrised N-port wormhole crossbar with per-input flit buffering.

---
 rtl/router_xbar_ravenoc_pkg.sv | 16 +
 rtl/router_xbar_ravenoc_if.sv | 27 ++
 rtl/router_xbar_ravenoc_rr_arbiter.sv | 31 +++
 rtl/router_xbar_ravenoc.sv | 151 +++++++++++++++
 tb/tb_router_xbar_ravenoc.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/router_xbar_ravenoc_pkg.sv
// router_xbar_ravenoc_pkg: flit and output-FSM types shared by the crossbar files
//   flit_type_t  : HEAD / BODY / TAIL / HEAD_TAIL wormhole flit kinds
//   xbar_state_t : per-output IDLE / LOCKED arbitration state
//   is_head()    : true for flits that open a packet
package router_xbar_ravenoc_pkg;
   typedef enum logic [1:0] {
      HEAD_FLIT      = 2'd0,
      BODY_FLIT      = 2'd1,
      TAIL_FLIT      = 2'd2,
      HEAD_TAIL_FLIT = 2'd3
   } flit_type_t;
   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} xbar_state_t;
   function automatic logic is_head(flit_type_t t);
      return t == HEAD_FLIT || t == HEAD_TAIL_FLIT;
   endfunction
endpackage

// File: rtl/router_xbar_ravenoc_if.sv
// router_xbar_ravenoc_if: flattened per-port link bundle of the crossbar
//   in_*  : N_PORTS input links (valid/ready, payload, flit type, one-hot dest)
//   out_* : N_PORTS registered output links (valid/ready, payload, type, packet counters)
//   master: traffic source/sink side, slave: crossbar side
interface router_xbar_ravenoc_if #(
   parameter int N_PORTS     = 5,
   parameter int FLIT_DATA_W = 32
);
   logic [N_PORTS-1:0]             in_valid_i;
   logic [N_PORTS-1:0]             in_ready_o;
   logic [N_PORTS*FLIT_DATA_W-1:0] in_flit_i;
   logic [N_PORTS*2-1:0]           in_type_i;
   logic [N_PORTS*N_PORTS-1:0]     in_dest_i;
   logic [N_PORTS-1:0]             out_valid_o;
   logic [N_PORTS-1:0]             out_ready_i;
   logic [N_PORTS*FLIT_DATA_W-1:0] out_flit_o;
   logic [N_PORTS*2-1:0]           out_type_o;
   logic [N_PORTS*16-1:0]          out_pkt_cnt_o;
   modport master (
      output in_valid_i, in_flit_i, in_type_i, in_dest_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_flit_o, out_type_o, out_pkt_cnt_o
   );
   modport slave (
      input  in_valid_i, in_flit_i, in_type_i, in_dest_i, out_ready_i,
      output in_ready_o, out_valid_o, out_flit_o, out_type_o, out_pkt_cnt_o
   );
endinterface

// File: rtl/router_xbar_ravenoc_rr_arbiter.sv
// router_xbar_ravenoc_rr_arbiter: round-robin pick among N requesters
//   req_i : request vector     ptr_i : index with highest priority
//   gnt_o : one-hot grant      idx_o : winner index     any_o : some request present
module router_xbar_ravenoc_rr_arbiter #(
   parameter int N = 5
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o,
   output logic                 any_o
);
   localparam int IW = $clog2(N);
   logic [IW:0] s;
   // Walk from the farthest offset down so the nearest requester after ptr_i is the last write.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      s     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         s = {1'b0, ptr_i} + (IW + 1)'(k);
         if (s >= (IW + 1)'(N)) s = s - (IW + 1)'(N);
         if (req_i[s[IW-1:0]]) begin
            gnt_o              = '0;
            gnt_o[s[IW-1:0]]   = 1'b1;
            idx_o              = s[IW-1:0];
         end
      end
   end
   assign any_o = |req_i;
endmodule

// File: rtl/router_xbar_ravenoc.sv
// router_xbar_ravenoc: N-port wormhole crossbar, per-input FIFOs, per-output round-robin locked per packet
//   clk, arst : clock and synchronous active-high reset
//   bus_io    : router_xbar_ravenoc_if.slave carrying all input and output links
//   Optional RAVENOC_XBAR_STATS_EN builds saturating per-output packet counters; otherwise they read 0.
module router_xbar_ravenoc
   import router_xbar_ravenoc_pkg::*;
#(
   parameter int N_PORTS     = 5,
   parameter int FLIT_DATA_W = 32,
   parameter int FIFO_DEPTH  = 2
) (
   input logic                  clk,
   input logic                  arst,
   router_xbar_ravenoc_if.slave bus_io
);
   localparam int IW = $clog2(N_PORTS);
   localparam int PW = $clog2(FIFO_DEPTH);
   typedef struct packed {
      flit_type_t               ftype;
      logic [N_PORTS-1:0]       dest;
      logic [FLIT_DATA_W-1:0]   data;
   } s_xbar_entry_t;
   s_xbar_entry_t          head [N_PORTS];
   logic [N_PORTS-1:0]     empty, full, pop, drop, cand, locked, disc_q, disc_d, ov_q, xfer, any;
   logic [N_PORTS-1:0]     low [N_PORTS];
   logic [N_PORTS-1:0]     rq [N_PORTS];
   logic [N_PORTS-1:0]     gnt [N_PORTS];
   logic [IW-1:0]          idx [N_PORTS];
   logic [IW-1:0]          src [N_PORTS];
   logic [IW-1:0]          owner_q [N_PORTS];
   logic [IW-1:0]          owner_d [N_PORTS];
   logic [IW-1:0]          ptr_q [N_PORTS];
   logic [IW-1:0]          ptr_d [N_PORTS];
   xbar_state_t            state_q [N_PORTS];
   xbar_state_t            state_d [N_PORTS];
   logic [FLIT_DATA_W-1:0] oflit_q [N_PORTS];
   flit_type_t             otype_q [N_PORTS];

   assign bus_io.in_ready_o  = ~full & {N_PORTS{~arst}};
   assign bus_io.out_valid_o = ov_q;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   for (genvar i = 0; i < N_PORTS; i++) begin : g_fifo
      s_xbar_entry_t mem [FIFO_DEPTH];
      logic [PW:0]   wr_q, rd_q;
      logic          push;
      assign push     = bus_io.in_valid_i[i] & ~full[i] & ~arst;
      assign empty[i] = wr_q == rd_q;
      assign full[i]  = wr_q == (rd_q ^ {1'b1, {PW{1'b0}}});
      assign head[i]  = mem[rd_q[PW-1:0]];
      always_ff @(posedge clk)
         if (push) mem[wr_q[PW-1:0]] <= '{flit_type_t'(bus_io.in_type_i[2*i+:2]),
                                          bus_io.in_dest_i[N_PORTS*i+:N_PORTS],
                                          bus_io.in_flit_i[FLIT_DATA_W*i+:FLIT_DATA_W]};
      always_ff @(posedge clk)
         if (arst) begin
            wr_q <= '0;
            rd_q <= '0;
         end else begin
            wr_q <= wr_q + (PW + 1)'(push);
            rd_q <= rd_q + (PW + 1)'(pop[i]);
         end
   end

   // Heads of unlocked inputs either request their lowest dest bit or are dropped:
   // orphans, illegal routes (zero / U-turn) and everything up to the TAIL of a dropped packet.
   always_comb begin
      locked = '0;
      for (int o = 0; o < N_PORTS; o++)
         if (state_q[o] == LOCKED) locked[owner_q[o]] = 1'b1;
      for (int i = 0; i < N_PORTS; i++) begin
         low[i]    = head[i].dest & (-head[i].dest);
         cand[i]   = !empty[i] && !locked[i] && !disc_q[i] && is_head(head[i].ftype) && low[i] != '0 && !low[i][i];
         drop[i]   = !empty[i] && !locked[i] && !cand[i];
         disc_d[i] = drop[i] ? (disc_q[i] ? head[i].ftype != TAIL_FLIT : head[i].ftype == HEAD_FLIT) : disc_q[i];
      end
      for (int o = 0; o < N_PORTS; o++)
         for (int i = 0; i < N_PORTS; i++) rq[o][i] = cand[i] & low[i][o];
   end

   for (genvar o = 0; o < N_PORTS; o++) begin : g_arb
      router_xbar_ravenoc_rr_arbiter #(.N(N_PORTS)) u_arb (
         .req_i (rq[o]),
         .ptr_i (ptr_q[o]),
         .gnt_o (gnt[o]),
         .idx_o (idx[o]),
         .any_o (any[o])
      );
   end

   // Each input requests a single output, so no input can be popped by two outputs.
   always_comb begin
      pop = drop;
      for (int o = 0; o < N_PORTS; o++) begin
         state_d[o] = state_q[o];
         owner_d[o] = owner_q[o];
         ptr_d[o]   = ptr_q[o];
         src[o]     = state_q[o] == LOCKED ? owner_q[o] : idx[o];
         xfer[o]    = (!ov_q[o] || bus_io.out_ready_i[o]) && (state_q[o] == LOCKED ? !empty[owner_q[o]] : any[o]);
         if (xfer[o] && state_q[o] == IDLE) begin
            pop        = pop | gnt[o];
            ptr_d[o]   = idx[o] == IW'(N_PORTS - 1) ? '0 : idx[o] + IW'(1);
            state_d[o] = head[idx[o]].ftype == HEAD_FLIT ? LOCKED : IDLE;
            owner_d[o] = idx[o];
         end else if (xfer[o]) begin
            pop[owner_q[o]] = 1'b1;
            state_d[o]      = head[owner_q[o]].ftype == TAIL_FLIT ? IDLE : LOCKED;
         end
      end
   end

   always_ff @(posedge clk)
      if (arst) begin
         disc_q <= '0;
         ov_q   <= '0;
         for (int o = 0; o < N_PORTS; o++) begin
            state_q[o] <= IDLE;
            owner_q[o] <= '0;
            ptr_q[o]   <= '0;
            oflit_q[o] <= '0;
            otype_q[o] <= HEAD_FLIT;
         end
      end else begin
         disc_q <= disc_d;
         for (int o = 0; o < N_PORTS; o++) begin
            state_q[o] <= state_d[o];
            owner_q[o] <= owner_d[o];
            ptr_q[o]   <= ptr_d[o];
            if (xfer[o]) begin
               ov_q[o]    <= 1'b1;
               oflit_q[o] <= head[src[o]].data;
               otype_q[o] <= head[src[o]].ftype;
            end else if (bus_io.out_ready_i[o]) ov_q[o] <= 1'b0;
         end
      end

   for (genvar o = 0; o < N_PORTS; o++) begin : g_out
      assign bus_io.out_flit_o[FLIT_DATA_W*o+:FLIT_DATA_W] = oflit_q[o];
      assign bus_io.out_type_o[2*o+:2]                     = otype_q[o];
`ifdef RAVENOC_XBAR_STATS_EN
      logic [15:0] cnt_q;
      always_ff @(posedge clk)
         if (arst) cnt_q <= '0;
         else if (ov_q[o] && bus_io.out_ready_i[o] && otype_q[o] inside {TAIL_FLIT, HEAD_TAIL_FLIT} && cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
      assign bus_io.out_pkt_cnt_o[16*o+:16] = cnt_q;
`else
      assign bus_io.out_pkt_cnt_o[16*o+:16] = '0;
`endif
   end
endmodule

// File: tb/tb_router_xbar_ravenoc.sv
// tb_router_xbar_ravenoc: directed checks of routing, arbitration, backpressure, drops and reset
module tb_router_xbar_ravenoc;
   import router_xbar_ravenoc_pkg::*;
   localparam int N = 5;
   localparam int W = 32;
`ifdef RAVENOC_XBAR_STATS_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif
   logic clk  = 1'b0;
   logic arst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   router_xbar_ravenoc_if #(.N_PORTS(N), .FLIT_DATA_W(W)) bif ();
   router_xbar_ravenoc #(.N_PORTS(N), .FLIT_DATA_W(W), .FIFO_DEPTH(2)) dut (
      .clk    (clk),
      .arst   (arst),
      .bus_io (bif)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] flit(int o);
      return bif.out_flit_o[W*o+:W];
   endfunction
   function automatic logic [31:0] ftyp(int o);
      return 32'(bif.out_type_o[2*o+:2]);
   endfunction
   function automatic logic [31:0] cnt(int o);
      return 32'(bif.out_pkt_cnt_o[16*o+:16]);
   endfunction
   function automatic logic [31:0] ov();
      return 32'(bif.out_valid_o);
   endfunction
   function automatic logic [31:0] rdy(int i);
      return 32'(bif.in_ready_o[i]);
   endfunction

   task automatic drv(int i, flit_type_t t, logic [N-1:0] d, logic [W-1:0] f);
      bif.in_valid_i[i]      = 1'b1;
      bif.in_type_i[2*i+:2]  = t;
      bif.in_dest_i[N*i+:N]  = d;
      bif.in_flit_i[W*i+:W]  = f;
   endtask
   task automatic idle(int i);
      bif.in_valid_i[i] = 1'b0;
   endtask
   task automatic do_reset();
      arst            = 1'b1;
      bif.in_valid_i  = '0;
      bif.out_ready_i = '1;
      tick();
      arst = 1'b0;
   endtask

   initial begin
      bif.in_valid_i  = '0;
      bif.in_flit_i   = '0;
      bif.in_type_i   = '0;
      bif.in_dest_i   = '0;
      bif.out_ready_i = '1;
      tick();
      tick();
      check("rst_ov", ov(), 32'h0);
      check("rst_ready_low", 32'(bif.in_ready_o), 32'h0);
      arst = 1'b0;
      #1;
      check("ready_after_rst", 32'(bif.in_ready_o), 32'h1f);
      check("cnt_after_rst", cnt(1), 32'h0);

      // single 3-flit packet in0 -> out1
      drv(0, HEAD_FLIT, 5'b00010, 32'hA0);
      tick();
      drv(0, BODY_FLIT, 5'b00010, 32'hA1);
      tick();
      check("t1_ov_head", ov(), 32'h02);
      check("t1_head", flit(1), 32'hA0);
      check("t1_head_type", ftyp(1), 32'(HEAD_FLIT));
      drv(0, TAIL_FLIT, 5'b00010, 32'hA2);
      tick();
      check("t1_body", flit(1), 32'hA1);
      idle(0);
      tick();
      check("t1_tail", flit(1), 32'hA2);
      check("t1_tail_type", ftyp(1), 32'(TAIL_FLIT));
      tick();
      check("t1_drained", ov(), 32'h0);
      check("t1_cnt", cnt(1), 32'(CNT_ON));

      // contention: in0 and in2 to out3, in0 wins and holds until its TAIL
      do_reset();
      drv(0, HEAD_FLIT, 5'b01000, 32'hB0);
      drv(2, HEAD_FLIT, 5'b01000, 32'hC0);
      tick();
      drv(0, BODY_FLIT, 5'b01000, 32'hB1);
      drv(2, BODY_FLIT, 5'b01000, 32'hC1);
      tick();
      check("t2_b0", flit(3), 32'hB0);
      drv(0, TAIL_FLIT, 5'b01000, 32'hB2);
      drv(2, TAIL_FLIT, 5'b01000, 32'hC2);
      tick();
      check("t2_b1", flit(3), 32'hB1);
      check("t2_in2_full", rdy(2), 32'h0);
      idle(0);
      tick();
      check("t2_b2", flit(3), 32'hB2);
      tick();
      check("t2_c0", flit(3), 32'hC0);
      check("t2_in2_ready", rdy(2), 32'h1);
      tick();
      check("t2_c1", flit(3), 32'hC1);
      idle(2);
      tick();
      check("t2_c2", flit(3), 32'hC2);
      check("t2_c2_type", ftyp(3), 32'(TAIL_FLIT));
      tick();
      check("t2_drained", ov(), 32'h0);

      // backpressure on out2 mid-packet
      do_reset();
      drv(1, HEAD_FLIT, 5'b00100, 32'hD0);
      tick();
      drv(1, BODY_FLIT, 5'b00100, 32'hD1);
      bif.out_ready_i[2] = 1'b0;
      tick();
      check("t3_d0", flit(2), 32'hD0);
      drv(1, BODY_FLIT, 5'b00100, 32'hD2);
      tick();
      check("t3_ready_drop", rdy(1), 32'h0);
      check("t3_hold_a", flit(2), 32'hD0);
      drv(1, BODY_FLIT, 5'b00100, 32'hD3);
      tick();
      tick();
      tick();
      check("t3_hold_b", flit(2), 32'hD0);
      check("t3_hold_valid", ov(), 32'h04);
      bif.out_ready_i[2] = 1'b1;
      tick();
      check("t3_d1", flit(2), 32'hD1);
      check("t3_ready_back", rdy(1), 32'h1);
      tick();
      check("t3_d2", flit(2), 32'hD2);
      drv(1, TAIL_FLIT, 5'b00100, 32'hD4);
      tick();
      check("t3_d3", flit(2), 32'hD3);
      idle(1);
      tick();
      check("t3_d4", flit(2), 32'hD4);
      tick();
      check("t3_drained", ov(), 32'h0);

      // HEAD_TAIL burst from in1..in4 to out0 rotates 1,2,3,4
      do_reset();
      for (int i = 1; i < N; i++) drv(i, HEAD_TAIL_FLIT, 5'b00001, 32'(16 * i));
      tick();
      for (int i = 1; i < N; i++) idle(i);
      tick();
      check("t4_g1", flit(0), 32'h10);
      check("t4_g1_type", ftyp(0), 32'(HEAD_TAIL_FLIT));
      tick();
      check("t4_g2", flit(0), 32'h20);
      tick();
      check("t4_g3", flit(0), 32'h30);
      tick();
      check("t4_g4", flit(0), 32'h40);
      tick();
      check("t4_drained", ov(), 32'h0);
      check("t4_cnt", cnt(0), 32'(4 * CNT_ON));

      // zero-dest packet is dropped, the following legal one is delivered
      do_reset();
      check("t5_cnt_cleared", cnt(0), 32'h0);
      drv(2, HEAD_FLIT, 5'b00000, 32'hF0);
      tick();
      drv(2, BODY_FLIT, 5'b00100, 32'hF1);
      tick();
      check("t5_drop_head", ov(), 32'h0);
      drv(2, TAIL_FLIT, 5'b00100, 32'hF2);
      tick();
      check("t5_drop_body", ov(), 32'h0);
      drv(2, HEAD_TAIL_FLIT, 5'b00010, 32'hF3);
      tick();
      check("t5_drop_tail", ov(), 32'h0);
      idle(2);
      tick();
      check("t5_legal_ov", ov(), 32'h02);
      check("t5_legal", flit(1), 32'hF3);
      drv(3, HEAD_TAIL_FLIT, 5'b01000, 32'hF4);
      tick();
      check("t5_accepted", ov(), 32'h0);
      idle(3);
      tick();
      check("t5_uturn", ov(), 32'h0);
      tick();
      check("t5_uturn_late", ov(), 32'h0);

      // reset while out2 is locked to in0, then a new packet from in1
      do_reset();
      drv(0, HEAD_FLIT, 5'b00100, 32'h60);
      tick();
      idle(0);
      tick();
      check("t6_head_fwd", ov(), 32'h04);
      arst = 1'b1;
      tick();
      check("t6_rst_ov", ov(), 32'h0);
      check("t6_rst_ready", 32'(bif.in_ready_o), 32'h0);
      arst = 1'b0;
      drv(1, HEAD_TAIL_FLIT, 5'b00100, 32'h61);
      tick();
      idle(1);
      tick();
      check("t6_new_ov", ov(), 32'h04);
      check("t6_new", flit(2), 32'h61);
      check("t6_new_type", ftyp(2), 32'(HEAD_TAIL_FLIT));

      // multi-hot dest: lowest set bit selects out1
      drv(4, HEAD_TAIL_FLIT, 5'b10110, 32'h77);
      tick();
      idle(4);
      tick();
      check("t6_multihot_ov", ov(), 32'h02);
      check("t6_multihot", flit(1), 32'h77);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
